m_imem_resp: RTL and testbench

Instruction-memory responder at the consumer end of the fetch PC stream. Accepts fetch requests (PC) from the PC-generation stage over a valid/ready handshake, performs a synchronous word read from an internal instruction RAM, and returns (PC, instruction) pairs in order to the decode side through a 2-entry response queue. Supports backpressure, pipeline flush on redirect, and a program-load write port.

---
 rtl/m_imem_resp_if.sv | 26 ++
 rtl/m_imem_resp.sv | 122 ++++++++++++
 tb/tb_m_imem_resp.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/m_imem_resp_if.sv
// Fetch-request, response and program-load signals between the PC stage,
// the instruction-memory responder and the decode side.
interface m_imem_resp_if;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_req_pc;
    logic        w_flush;
    logic        w_rsp_valid;
    logic        w_rsp_ready;
    logic [31:0] w_rsp_pc;
    logic [31:0] w_rsp_ir;
    logic        w_rsp_err;
    logic        w_we;
    logic [31:0] w_waddr;
    logic [31:0] w_wdata;

    modport master (
        output w_req_valid, w_req_pc, w_flush, w_rsp_ready, w_we, w_waddr, w_wdata,
        input  w_req_ready, w_rsp_valid, w_rsp_pc, w_rsp_ir, w_rsp_err
    );

    modport slave (
        input  w_req_valid, w_req_pc, w_flush, w_rsp_ready, w_we, w_waddr, w_wdata,
        output w_req_ready, w_rsp_valid, w_rsp_pc, w_rsp_ir, w_rsp_err
    );
endinterface

// File: rtl/m_imem_resp.sv
// Instruction-memory responder: synchronous RAM read per accepted PC, one
// in-flight slot feeding a 2-entry in-order response queue, flush and load port.
module m_imem_resp #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] NOP_IR    = 32'h00000013
) (
    input logic         w_clk,
    input logic         w_rst_n,
    m_imem_resp_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rd_q;

    logic        slot_v, slot_v_nx;
    logic [31:0] slot_pc, slot_pc_nx;
    logic        slot_err, slot_err_nx;
    logic [31:0] slot_ir;

    logic [1:0]  n, n_nx, n_tmp;
    logic [31:0] f_pc  [2];
    logic [31:0] f_ir  [2];
    logic        f_err [2];
    logic [31:0] f_pc_nx  [2];
    logic [31:0] f_ir_nx  [2];
    logic        f_err_nx [2];

    logic          head_fifo, rsp_valid_i, pop, push, req_ready_i, accept, req_err;
    logic [2:0]    occ;
    logic [AW-1:0] ridx, widx;
    logic          wr_in_range;
    logic          unused_waddr_lsb;

    assign ridx             = bus.w_req_pc[AW+1:2];
    assign widx             = bus.w_waddr[AW+1:2];
    assign wr_in_range      = (bus.w_waddr[31:AW+2] == '0);
    assign req_err          = (bus.w_req_pc[1:0] != 2'b00) | (bus.w_req_pc[31:AW+2] != '0);
    assign unused_waddr_lsb = ^bus.w_waddr[1:0];

    // Head selection and credit; ready looks through this cycle's pop.
    always_comb begin
        head_fifo   = (n != 2'd0);
        rsp_valid_i = w_rst_n & (head_fifo | slot_v);
        slot_ir     = slot_err ? NOP_IR : rd_q;
        pop         = rsp_valid_i & bus.w_rsp_ready;
        occ         = {1'b0, n} + {2'b00, slot_v} - {2'b00, pop};
        req_ready_i = w_rst_n & ~bus.w_flush & (occ < 3'd2);
        accept      = bus.w_req_valid & req_ready_i;

        bus.w_req_ready = req_ready_i;
        bus.w_rsp_valid = rsp_valid_i;
        bus.w_rsp_pc    = head_fifo ? f_pc[0]  : slot_pc;
        bus.w_rsp_ir    = head_fifo ? f_ir[0]  : slot_ir;
        bus.w_rsp_err   = head_fifo ? f_err[0] : slot_err;
    end

    always_comb begin
        f_pc_nx  = f_pc;
        f_ir_nx  = f_ir;
        f_err_nx = f_err;
        n_tmp    = n;

        if (pop && head_fifo) begin
            f_pc_nx[0]  = f_pc[1];
            f_ir_nx[0]  = f_ir[1];
            f_err_nx[0] = f_err[1];
            n_tmp       = n - 2'd1;
        end

        // The slot always drains: either popped directly as head or queued.
        push = slot_v & ~(pop & ~head_fifo);
        if (push) begin
            if (n_tmp == 2'd0) begin
                f_pc_nx[0]  = slot_pc;
                f_ir_nx[0]  = slot_ir;
                f_err_nx[0] = slot_err;
            end else begin
                f_pc_nx[1]  = slot_pc;
                f_ir_nx[1]  = slot_ir;
                f_err_nx[1] = slot_err;
            end
            n_tmp = n_tmp + 2'd1;
        end

        n_nx        = n_tmp;
        slot_v_nx   = accept;
        slot_pc_nx  = accept ? bus.w_req_pc : slot_pc;
        slot_err_nx = accept ? req_err      : slot_err;

        if (bus.w_flush) begin
            n_nx      = 2'd0;
            slot_v_nx = 1'b0;
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            n      <= 2'd0;
            slot_v <= 1'b0;
        end else begin
            n      <= n_nx;
            slot_v <= slot_v_nx;
        end
    end

    always_ff @(posedge w_clk) begin
        slot_pc  <= slot_pc_nx;
        slot_err <= slot_err_nx;
        f_pc     <= f_pc_nx;
        f_ir     <= f_ir_nx;
        f_err    <= f_err_nx;
    end

    // Read-first: the read below sees the word before this edge's write.
    always_ff @(posedge w_clk) begin
        if (w_rst_n && bus.w_we && wr_in_range)
            mem[widx] <= bus.w_wdata;
        if (accept)
            rd_q <= mem[ridx];
    end
endmodule

// File: tb/tb_m_imem_resp.sv
// Bench for m_imem_resp: directed scenarios plus random traffic checked against
// a queue-based model of outstanding responses and a shadow memory.
module tb_m_imem_resp;
    localparam int unsigned MW  = 1024;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        err;
    } rsp_t;

    logic w_clk;
    logic w_rst_n;
    m_imem_resp_if bus();

    m_imem_resp #(.MEM_WORDS(MW), .NOP_IR(NOP)) dut (
        .w_clk  (w_clk),
        .w_rst_n(w_rst_n),
        .bus    (bus)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int          errors = 0;
    int          checks = 0;
    rsp_t        q[$];
    logic [31:0] mm [MW];
    bit          last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance the model at the edge.
    task automatic step(input bit rv, input logic [31:0] pc, input bit rr, input bit fl,
                        input bit we, input logic [31:0] wa, input logic [31:0] wd,
                        input bit rst = 1'b1);
        bit   exp_valid, exp_ready, pop, err;
        int   sz;
        rsp_t e;
        @(negedge w_clk);
        w_rst_n         = rst;
        bus.w_req_valid = rv;
        bus.w_req_pc    = pc;
        bus.w_rsp_ready = rr;
        bus.w_flush     = fl;
        bus.w_we        = we;
        bus.w_waddr     = wa;
        bus.w_wdata     = wd;
        #1;
        sz        = q.size();
        exp_valid = rst && (sz > 0);
        pop       = exp_valid && rr;
        exp_ready = rst && !fl && ((sz - int'(pop)) < 2);
        chk("rsp_valid", {31'd0, bus.w_rsp_valid}, {31'd0, exp_valid});
        chk("req_ready", {31'd0, bus.w_req_ready}, {31'd0, exp_ready});
        if (exp_valid) begin
            chk("rsp_pc", bus.w_rsp_pc, q[0].pc);
            chk("rsp_ir", bus.w_rsp_ir, q[0].ir);
            chk("rsp_err", {31'd0, bus.w_rsp_err}, {31'd0, q[0].err});
        end
        @(posedge w_clk);
        last_acc = rv && exp_ready;
        if (!rst) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (fl) q.delete();
            else if (last_acc) begin
                err   = (pc[1:0] != 2'b00) || (pc >= 4 * MW);
                e.pc  = pc;
                e.err = err;
                e.ir  = err ? NOP : mm[pc[11:2]];
                q.push_back(e);
            end
            if (we && wa < 4 * MW) mm[wa[11:2]] = wd;
        end
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 32'd0, rr, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic wr(input int word, input logic [31:0] d);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'(word * 4), d);
    endtask

    initial begin
        logic [31:0] pcs[3];
        int          k, cyc;
        logic [31:0] rpc, wa;
        bit          rv, rr, fl, we, rst;

        w_rst_n = 1'b0;
        bus.w_req_valid = 1'b0; bus.w_req_pc = '0; bus.w_rsp_ready = 1'b0;
        bus.w_flush = 1'b0; bus.w_we = 1'b0; bus.w_waddr = '0; bus.w_wdata = '0;

        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        wr(0, 32'd11); wr(1, 32'd22); wr(2, 32'd33); wr(3, 32'd44);
        for (int w = 4; w < 16; w++) wr(w, $urandom);

        // Streaming with consumer always ready.
        for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(1'b1);

        // Backpressure: consumer stalls 4 cycles, then drains.
        pcs[0] = 32'd0; pcs[1] = 32'd4; pcs[2] = 32'd8;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            step(k < 3, pcs[k < 3 ? k : 2], c >= 4, 1'b0, 1'b0, 32'd0, 32'd0);
            if (c == 3) chk("stall_accepts", 32'(k), 32'd2);
            if (last_acc) k++;
        end
        chk("stall_all_accepted", 32'(k), 32'd3);

        // Misaligned and out-of-range requests.
        step(1'b1, 32'd6, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'(4 * MW), 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(1'b1);

        // Flush with two responses queued and a request offered.
        step(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd8, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        chk("flush_no_accept", {31'd0, last_acc}, 32'd0);
        step(1'b1, 32'd12, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("post_flush_ir", bus.w_rsp_ir, 32'd44);
        idle(1'b1);

        // Same-cycle write and read of word 1.
        step(1'b1, 32'd4, 1'b1, 1'b0, 1'b1, 32'd4, 32'd55);
        #1;
        chk("read_first_ir", bus.w_rsp_ir, 32'd22);
        step(1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("read_new_ir", bus.w_rsp_ir, 32'd55);
        idle(1'b1);

        // Out-of-range write must not alias onto word 0.
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'(4 * MW), 32'hdead_beef);

        // Reset with a response pending.
        step(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        idle(1'b0);
        step(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("ram_after_reset", bus.w_rsp_ir, 32'd11);
        idle(1'b1);

        // Random traffic.
        for (cyc = 0; cyc < 500; cyc++) begin
            case ($urandom_range(0, 9))
                0:       rpc = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                1:       rpc = 32'(4 * MW) + 32'($urandom_range(0, 255) * 4);
                default: rpc = 32'($urandom_range(0, 15) * 4);
            endcase
            rv  = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            we  = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 59) != 0);
            wa  = ($urandom_range(0, 3) == 0) ? 32'(4 * MW + $urandom_range(0, 63) * 4)
                                              : 32'($urandom_range(0, 15) * 4);
            step(rv, rpc, rr, fl, we, wa, $urandom, rst);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
